// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: pops a word from the TX FIFO and serialises it
// as start bit, DBIT data bits (LSB first), optional parity bit and stop bit.
// All bit timing is counted in s_tick pulses (16 per bit period).
module uart_tx_sequencer #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            enable,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rd_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  // Tick counter must reach 15 for data bits and SB_TICK-1 for the stop bit.
  localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int BW = ($clog2(DBIT) > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] TICK_BIT  = TW'(15);
  localparam logic [TW-1:0] TICK_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PAR, STOP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic            par_q, par_d;
  logic            tx_d, done_d;

  assign busy = (state_q != IDLE);

  // Next-state, counters, shift register and FIFO pop strobe.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    done_d  = 1'b0;
    fifo_rd = 1'b0;
    case (state_q)
      IDLE: if (enable && !fifo_empty) state_d = LOAD;
      LOAD: begin
        // s_tick is deliberately ignored here.
        fifo_rd = !fifo_empty;
        sh_d    = fifo_rd_data;
        // Parity is taken from the captured word, not the shifting copy.
        par_d   = (^fifo_rd_data) ^ (PARITY == 2);
        tick_d  = '0;
        state_d = START;
      end
      START: if (s_tick) begin
        if (tick_q == TICK_BIT) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else tick_d = tick_q + TW'(1);
      end
      DATA: if (s_tick) begin
        if (tick_q == TICK_BIT) begin
          tick_d = '0;
          sh_d   = sh_q >> 1;
          if (bit_q == BIT_LAST) state_d = (PARITY != 0) ? PAR : STOP;
          else                   bit_d   = bit_q + BW'(1);
        end else tick_d = tick_q + TW'(1);
      end
      PAR: if (s_tick) begin
        if (tick_q == TICK_BIT) begin
          tick_d  = '0;
          state_d = STOP;
        end else tick_d = tick_q + TW'(1);
      end
      STOP: if (s_tick) begin
        if (tick_q == TICK_STOP) begin
          tick_d  = '0;
          done_d  = 1'b1;
          // A FIFO refill during STOP chains straight into the next frame.
          state_d = (enable && !fifo_empty) ? LOAD : IDLE;
        end else tick_d = tick_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (rst) fifo_rd = 1'b0;
  end

  // Line level derived from the next state so tx is right in a state's first cycle.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      par_q        <= 1'b0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      par_q        <= par_d;
      tx           <= tx_d;
      tx_done_tick <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench: three instances (no parity, even, odd) each fed by a small
// FIFO model; frame bit patterns are hand-written in a vector table.
module tb_uart_tx_sequencer;

  logic clk = 1'b0;
  logic rst, enable, s_tick;
  int   tick_div = 1;
  int   tcnt = 0;

  logic [7:0] fmem [3][8];
  int         fhead [3];
  int         ftail [3];

  logic [2:0] emp, rd, txv, busyv, donev;
  logic [7:0] rdd [3];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) tcnt <= (tcnt == 3) ? 0 : tcnt + 1;
  assign s_tick = (tick_div == 1) || (tcnt == 0);

  assign emp[0] = (fhead[0] == ftail[0]);
  assign emp[1] = (fhead[1] == ftail[1]);
  assign emp[2] = (fhead[2] == ftail[2]);
  assign rdd[0] = fmem[0][fhead[0][2:0]];
  assign rdd[1] = fmem[1][fhead[1][2:0]];
  assign rdd[2] = fmem[2][fhead[2][2:0]];

  // FIFO pop side.
  always @(posedge clk)
    for (int s = 0; s < 3; s++) if (rd[s]) fhead[s] <= fhead[s] + 1;

  uart_tx_sequencer #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .enable(enable),
    .fifo_empty(emp[0]), .fifo_rd_data(rdd[0]), .fifo_rd(rd[0]),
    .tx(txv[0]), .busy(busyv[0]), .tx_done_tick(donev[0]));

  uart_tx_sequencer #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .enable(enable),
    .fifo_empty(emp[1]), .fifo_rd_data(rdd[1]), .fifo_rd(rd[1]),
    .tx(txv[1]), .busy(busyv[1]), .tx_done_tick(donev[1]));

  uart_tx_sequencer #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .enable(enable),
    .fifo_empty(emp[2]), .fifo_rd_data(rdd[2]), .fifo_rd(rd[2]),
    .tx(txv[2]), .busy(busyv[2]), .tx_done_tick(donev[2]));

  typedef struct {
    logic [7:0]  data;
    int          sel;
    logic [10:0] bits;   // bit k = expected tx level in bit period k
    int          nb;     // bit periods per frame
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d);
    fmem[s][ftail[s][2:0]] = d;
    ftail[s] = ftail[s] + 1;
  endtask

  // Waits (bounded) for the LOAD cycle of instance sel; returns at its negedge.
  task automatic wait_rd(input int sel, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd[sel]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("load_seen", int'(seen), 1);
  endtask

  // Starting at a LOAD negedge, checks every bit mid-period and the done pulse
  // in the cycle after the stop bit ends (every-cycle s_tick).
  task automatic check_frame(input int sel, input logic [10:0] bits, input int nb);
    int last = 16 * nb + 1;
    int dn = 0;
    int dcyc = -1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c % 16 == 8) chk($sformatf("u%0d_bit%0d", sel, c / 16), int'(txv[sel]), int'(bits[c / 16]));
      if (c == 8) chk("busy_mid", int'(busyv[sel]), 1);
      if (donev[sel]) begin
        dn++;
        dcyc = c;
      end
    end
    chk("done_cnt", dn, 1);
    chk("done_cyc", dcyc, last);
  endtask

  initial begin
    int t [16];
    int n, dc, prev, rcnt, dcnt;
    bit quiet;

    tbl[0] = '{8'h55, 0, 11'h2AA, 10};
    tbl[1] = '{8'hFF, 0, 11'h3FE, 10};
    tbl[2] = '{8'h07, 1, 11'h60E, 11};
    tbl[3] = '{8'h07, 2, 11'h40E, 11};
    tbl[4] = '{8'h00, 1, 11'h400, 11};
    tbl[5] = '{8'h00, 2, 11'h600, 11};

    for (int s = 0; s < 3; s++) begin
      fhead[s] = 0;
      ftail[s] = 0;
    end
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(txv[0]), 1);
    chk("rst_busy", int'(busyv[0]), 0);
    chk("rst_rd", int'(rd[0]), 0);
    chk("rst_done", int'(donev[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table of single frames across all three parity settings.
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].sel, tbl[i].data);
      wait_rd(tbl[i].sel, 20);
      check_frame(tbl[i].sel, tbl[i].bits, tbl[i].nb);
      chk("idle_busy", int'(busyv[tbl[i].sel]), 0);
      chk("fifo_empty", int'(emp[tbl[i].sel]), 1);
    end

    // Back-to-back frames: second LOAD in the done cycle, no extra idle gap.
    push(0, 8'hA3);
    push(0, 8'h0F);
    wait_rd(0, 20);
    check_frame(0, 11'h346, 10);
    chk("b2b_load", int'(rd[0]), 1);
    chk("b2b_tx_high", int'(txv[0]), 1);
    check_frame(0, 11'h21E, 10);
    chk("b2b_busy", int'(busyv[0]), 0);
    chk("b2b_empty", int'(emp[0]), 1);
    chk("b2b_pops", fhead[0], ftail[0]);

    // enable=0 with data waiting: no pop, line stays high.
    enable = 1'b0;
    push(0, 8'h12);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd[0] || !txv[0] || busyv[0]) quiet = 1'b0;
    end
    chk("gate_quiet", int'(quiet), 1);
    enable = 1'b1;
    wait_rd(0, 5);
    check_frame(0, 11'h224, 10);

    // Dropping enable mid-DATA finishes the frame then idles.
    push(0, 8'h55);
    push(0, 8'hFF);
    wait_rd(0, 5);
    dc = -1;
    for (int c = 1; c <= 161; c++) begin
      @(negedge clk);
      if (c == 40) enable = 1'b0;
      if (c == 72) chk("drop_bit3", int'(txv[0]), 0);
      if (donev[0]) dc = c;
    end
    chk("drop_done", dc, 161);
    chk("drop_busy", int'(busyv[0]), 0);
    chk("drop_no_rd", int'(rd[0]), 0);
    enable = 1'b1;
    wait_rd(0, 5);
    check_frame(0, 11'h3FE, 10);

    // Reset in data bit 3 aborts the frame; no pop while reset is held.
    push(0, 8'h55);
    wait_rd(0, 5);
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busyv[0]), 0);
    chk("mid_rst_tx", int'(txv[0]), 1);
    push(0, 8'h00);
    rcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rd[0]) rcnt++;
      if (donev[0]) dcnt++;
    end
    chk("rst_no_pop", rcnt, 0);
    chk("rst_no_done", dcnt, 0);
    rst = 1'b0;
    wait_rd(0, 5);
    check_frame(0, 11'h200, 10);

    // Sparse ticks: each bit after the start bit spans exactly 64 cycles.
    tick_div = 4;
    push(0, 8'h55);
    wait_rd(0, 20);
    n = 0;
    dc = -1;
    prev = int'(txv[0]);
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      if (int'(txv[0]) != prev) begin
        if (n < 16) t[n] = c;
        n++;
        prev = int'(txv[0]);
      end
      if (donev[0]) begin
        dc = c;
        break;
      end
    end
    chk("sparse_edges", n, 10);
    if (n == 10) begin
      chk("sparse_fall", t[0], 1);
      chk("sparse_start_len", int'((t[1] - t[0]) >= 61 && (t[1] - t[0]) <= 64), 1);
      for (int k = 1; k < 9; k++) chk($sformatf("sparse_bit%0d", k), t[k + 1] - t[k], 64);
      chk("sparse_done", dc, t[9] + 64);
    end
    chk("sparse_busy", int'(busyv[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
